// File: rtl/gpio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpio_bus_arbiter
// Brief    : Two-master arbiter and single-cycle transfer sequencer for the
//            AHB GPIO/scratch register slave.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_bus_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_write,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_write,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              S_HSEL,
    output logic [ADDR_W-1:0] S_HADDR,
    output logic [DATA_W-1:0] S_HWDATA,
    output logic              S_HWRITE,
    input  logic [DATA_W-1:0] S_HRDATA
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic c_fixed_prio = (FIXED_PRIO != 0);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_last_grant;   // 0 = M0, 1 = M1
    logic              r_owner;        // master owning the current transfer
    logic              r_write;
    logic [ADDR_W-1:0] r_haddr;
    logic [DATA_W-1:0] r_hwdata;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;
    logic              w_any_req;
    logic              w_grant_m1;

    assign w_any_req  = m0_req | m1_req;
    // M1 wins when alone, or in round-robin mode when M0 held the last grant.
    assign w_grant_m1 = m1_req & (~m0_req | (~c_fixed_prio & ~r_last_grant));

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_next_state = ST_XFER;
            ST_XFER: w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        S_HSEL   = 1'b0;
        S_HWRITE = 1'b0;
        m0_done  = 1'b0;
        m1_done  = 1'b0;
        case (r_state)
            ST_XFER: begin
                S_HSEL   = 1'b1;
                S_HWRITE = r_write;
            end
            ST_RESP: begin
                m0_done = ~r_owner;
                m1_done = r_owner;
            end
            default: ;
        endcase
    end

    // Request latch, grant history and read-data capture
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_write      <= 1'b0;
            r_haddr      <= '0;
            r_hwdata     <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any_req) begin
                r_owner      <= w_grant_m1;
                r_last_grant <= w_grant_m1;
                r_write      <= w_grant_m1 ? m1_write : m0_write;
                r_haddr      <= w_grant_m1 ? m1_addr  : m0_addr;
                r_hwdata     <= w_grant_m1 ? m1_wdata : m0_wdata;
            end
            if (r_state == ST_XFER && !r_write) begin
                if (r_owner) r_m1_rdata <= S_HRDATA;
                else         r_m0_rdata <= S_HRDATA;
            end
        end
    end

    assign S_HADDR  = r_haddr;
    assign S_HWDATA = r_hwdata;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_gpio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_bus_arbiter
// Brief    : Directed self-checking bench for gpio_bus_arbiter (round-robin
//            and fixed-priority instances) with a register-file slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_bus_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic              m0_req = 1'b0, m1_req = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
    logic              m0_write = 1'b0, m1_write = 1'b0;

    logic              m0_done, m1_done, s_hsel, s_hwrite;
    logic [DATA_W-1:0] m0_rdata, m1_rdata, s_hwdata, s_hrdata;
    logic [ADDR_W-1:0] s_haddr;

    logic              fp_m0_done, fp_m1_done, fp_hsel, fp_hwrite;
    logic [DATA_W-1:0] fp_m0_rdata, fp_m1_rdata, fp_hwdata, fp_hrdata;
    logic [ADDR_W-1:0] fp_haddr;

    logic [DATA_W-1:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    gpio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
        .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
        .m1_done(m1_done), .m1_rdata(m1_rdata),
        .S_HSEL(s_hsel), .S_HADDR(s_haddr), .S_HWDATA(s_hwdata), .S_HWRITE(s_hwrite),
        .S_HRDATA(s_hrdata)
    );

    gpio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(1)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
        .m0_done(fp_m0_done), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
        .m1_done(fp_m1_done), .m1_rdata(fp_m1_rdata),
        .S_HSEL(fp_hsel), .S_HADDR(fp_haddr), .S_HWDATA(fp_hwdata), .S_HWRITE(fp_hwrite),
        .S_HRDATA(fp_hrdata)
    );

    // Register-file slave: combinational read, write on the closing edge.
    assign s_hrdata  = mem[s_haddr];
    assign fp_hrdata = {28'h0, fp_haddr};

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
    end

    always @(posedge HCLK) begin
        if (s_hsel && s_hwrite) mem[s_haddr] <= s_hwdata;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_hsel",   32'(s_hsel), 32'h0);
        check("rst_hwrite", 32'(s_hwrite), 32'h0);
        check("rst_haddr",  32'(s_haddr), 32'h0);
        check("rst_done",   32'({m0_done, m1_done}), 32'h0);
        check("rst_rdata0", m0_rdata, 32'h0);
        check("rst_rdata1", m1_rdata, 32'h0);

        // M0 write only
        m0_req = 1'b1; m0_addr = 4'h4; m0_wdata = 32'hDEADBEEF; m0_write = 1'b1;
        tick();
        check("w0_hsel",   32'(s_hsel), 32'h1);
        check("w0_hwrite", 32'(s_hwrite), 32'h1);
        check("w0_haddr",  32'(s_haddr), 32'h4);
        check("w0_hwdata", s_hwdata, 32'hDEADBEEF);
        check("w0_nodone", 32'(m0_done), 32'h0);
        tick();
        check("w0_done",    32'(m0_done), 32'h1);
        check("w0_m1done",  32'(m1_done), 32'h0);
        check("w0_hsel_lo", 32'({s_hsel, s_hwrite}), 32'h0);
        check("w0_rdata",   m0_rdata, 32'h0);
        check("w0_mem",     mem[4], 32'hDEADBEEF);
        m0_req = 1'b0;
        tick();
        check("w0_done_lo", 32'(m0_done), 32'h0);
        tick();
        check("w0_nogrant", 32'(s_hsel), 32'h0);
        check("w0_haddr_hold", 32'(s_haddr), 32'h4);

        // M1 read only
        m1_req = 1'b1; m1_addr = 4'h4; m1_wdata = 32'h0; m1_write = 1'b0;
        tick();
        check("r1_hsel",   32'(s_hsel), 32'h1);
        check("r1_hwrite", 32'(s_hwrite), 32'h0);
        tick();
        check("r1_done",   32'(m1_done), 32'h1);
        check("r1_m0done", 32'(m0_done), 32'h0);
        check("r1_rdata",  m1_rdata, 32'hDEADBEEF);
        m1_req = 1'b0;
        tick();
        check("r1_done_lo", 32'(m1_done), 32'h0);
        check("r1_persist", m1_rdata, 32'hDEADBEEF);
        check("r1_m0rdata", m0_rdata, 32'h0);

        // First contest after reset: M0 then M1
        do_reset();
        m0_req = 1'b1; m0_addr = 4'h1; m0_wdata = 32'h11; m0_write = 1'b1;
        m1_req = 1'b1; m1_addr = 4'h2; m1_wdata = 32'h22; m1_write = 1'b1;
        tick();
        check("c_n1_haddr", 32'(s_haddr), 32'h1);
        tick();
        check("c_n2_done", 32'({m0_done, m1_done}), 32'h2);
        m0_req = 1'b0;
        tick();
        check("c_n3_hsel", 32'(s_hsel), 32'h0);
        tick();
        check("c_n4_hsel",  32'(s_hsel), 32'h1);
        check("c_n4_haddr", 32'(s_haddr), 32'h2);
        tick();
        check("c_n5_done", 32'({m0_done, m1_done}), 32'h1);
        m1_req = 1'b0;
        tick();
        check("c_mem1", mem[1], 32'h11);
        check("c_mem2", mem[2], 32'h22);

        // Continuous contention, six transfers, both arbitration modes
        do_reset();
        m0_req = 1'b1; m0_addr = 4'h1; m0_wdata = 32'h0; m0_write = 1'b0;
        m1_req = 1'b1; m1_addr = 4'h2; m1_wdata = 32'h0; m1_write = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            tick();
            check("rr_m0done", 32'(m0_done), (k % 2 == 0) ? 32'h1 : 32'h0);
            check("rr_m1done", 32'(m1_done), (k % 2 == 0) ? 32'h0 : 32'h1);
            check("fp_m0done", 32'(fp_m0_done), 32'h1);
            check("fp_m1done", 32'(fp_m1_done), 32'h0);
            if (k == 5) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            tick();
        end
        check("rr_m0rdata", m0_rdata, 32'h11);
        check("rr_m1rdata", m1_rdata, 32'h22);
        check("fp_m0rdata", fp_m0_rdata, 32'h1);
        check("fp_m1rdata", fp_m1_rdata, 32'h0);
        check("fp_hw", {fp_hwdata[30:0], fp_hwrite | fp_hsel}, 32'h0);

        // Reset during an M1 write in XFER
        m1_req = 1'b1; m1_addr = 4'h2; m1_wdata = 32'h5; m1_write = 1'b1;
        tick();
        check("rx_hsel", 32'(s_hsel), 32'h1);
        #2 HRESETn = 1'b0;
        #1;
        check("rx_hsel_async", 32'({s_hsel, s_hwrite}), 32'h0);
        m1_req = 1'b0;
        tick();
        check("rx_nowrite", mem[2], 32'h22);
        check("rx_nodone",  32'(m1_done), 32'h0);
        m0_req = 1'b1; m0_addr = 4'h3; m0_wdata = 32'h33; m0_write = 1'b1;
        m1_req = 1'b1;
        HRESETn = 1'b1;
        tick();
        check("rx_m0_haddr", 32'(s_haddr), 32'h3);
        tick();
        check("rx_m0_done", 32'({m0_done, m1_done}), 32'h2);
        m0_req = 1'b0;
        tick();
        tick();
        tick();
        check("rx_m1_done", 32'({m0_done, m1_done}), 32'h1);
        m1_req = 1'b0;
        tick();
        check("rx_mem2", mem[2], 32'h5);
        check("rx_mem3", mem[3], 32'h33);

        // Requester drops req while in XFER
        m0_req = 1'b1; m0_addr = 4'h3; m0_write = 1'b0;
        tick();
        m0_req = 1'b0;
        check("dr_hsel", 32'(s_hsel), 32'h1);
        tick();
        check("dr_done",  32'(m0_done), 32'h1);
        check("dr_rdata", m0_rdata, 32'h33);
        tick();
        tick();
        check("dr_noregrant", 32'({s_hsel, m0_done, m1_done}), 32'h0);
        check("dr_hold", m0_rdata, 32'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
